// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if -- bundle of the fetch unit's handshake and data signals.
//
// Signals:
//   inst_addr, inst_req_valid, inst_req_ready        : fetch request channel
//   inst_rsp_valid, inst_data                        : in-order fetch response
//   redirect_valid, redirect_pc                      : change-of-flow request
//   out_valid, out_pc, out_inst, out_ready           : instruction stream to decode
//
// Modports:
//   master : the fetch unit (drives requests and the decode stream)
//   slave  : the environment (memory, branch unit and decode)
interface ifu_fetch_if;
    logic [31:0] inst_addr;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic        inst_rsp_valid;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    modport master (
        output inst_addr, inst_req_valid, out_valid, out_pc, out_inst,
        input  inst_req_ready, inst_rsp_valid, inst_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  inst_addr, inst_req_valid, out_valid, out_pc, out_inst,
        output inst_req_ready, inst_rsp_valid, inst_data,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch -- in-order instruction-fetch initiator.
//
// Holds the PC, issues fetch requests under a credit limit, tags each
// response with the PC it was fetched from and buffers {pc, inst} pairs
// toward decode. A redirect reloads the PC, flushes the buffer and marks
// every outstanding response as stale so it is discarded on arrival.
//
// Ports:
//   clk        : single clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   bus        : ifu_fetch_if.master (request, response, redirect, decode stream)
//   fetch_cnt  : 64-bit count of decode handshakes (only with IFU_PERF_CNT_EN)
//
// Build option:
//   IFU_PERF_CNT_EN : adds the fetch_cnt port and its counter.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] fetch_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] out_count;
    logic [AW-1:0] tag_wr, tag_rd;
    logic [AW-1:0] out_wr, out_rd;

    logic [31:0] tag_mem      [FIFO_DEPTH];
    logic [31:0] out_pc_mem   [FIFO_DEPTH];
    logic [31:0] out_inst_mem [FIFO_DEPTH];

    logic credit_ok;
    logic req_valid;
    logic accept;
    logic rsp;
    logic rsp_keep;
    logic out_valid;
    logic pop;

    always_comb begin
        // Buffered plus outstanding instructions may never exceed the buffer,
        // so every response always finds a free slot.
        credit_ok = ({1'b0, inflight} + {1'b0, out_count}) < (CW+1)'(FIFO_DEPTH);
        req_valid = rst_n && !bus.redirect_valid && credit_ok;
        accept    = req_valid && bus.inst_req_ready;
        rsp       = bus.inst_rsp_valid;
        rsp_keep  = rsp && !bus.redirect_valid && (drop == '0);
        out_valid = (out_count != '0);
        pop       = out_valid && bus.out_ready;
    end

    assign bus.inst_addr      = pc;
    assign bus.inst_req_valid = req_valid;
    assign bus.out_valid      = out_valid;
    // Gated so the outputs read zero whenever the buffer is empty.
    assign bus.out_pc         = out_valid ? out_pc_mem[out_rd]   : 32'd0;
    assign bus.out_inst       = out_valid ? out_inst_mem[out_rd] : 32'd0;

    // Control state: PC, credit counters and queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            inflight  <= '0;
            drop      <= '0;
            tag_wr    <= '0;
            tag_rd    <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp);
            if (accept) tag_wr <= tag_wr + AW'(1);
            if (rsp)    tag_rd <= tag_rd + AW'(1);

            if (bus.redirect_valid) begin
                pc        <= bus.redirect_pc & ~32'd3;
                // Everything still outstanding after this edge is stale,
                // whether or not it was already marked for dropping.
                drop      <= inflight - CW'(rsp);
                out_wr    <= '0;
                out_rd    <= '0;
                out_count <= '0;
            end else begin
                if (accept)                pc   <= pc + 32'd4;
                if (rsp && (drop != '0))   drop <= drop - CW'(1);
                if (rsp_keep)              out_wr <= out_wr + AW'(1);
                if (pop)                   out_rd <= out_rd + AW'(1);
                out_count <= out_count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // Queue storage: contents are only meaningful behind valid pointers.
    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wr] <= pc;
        if (rsp_keep) begin
            out_pc_mem[out_wr]   <= tag_mem[tag_rd];
            out_inst_mem[out_wr] <= bus.inst_data;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)   fetch_cnt <= 64'd0;
        else if (pop) fetch_cnt <= fetch_cnt + 64'd1;
    end
`endif
endmodule
